instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, instruction presented while id_valid=0.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 stall  in  1  decoder hazard stall; hold the current ID output.
REQ-006 jmp  in  1  redirect request from execute.
REQ-007 jmp_pc  in  32  redirect target byte address.
REQ-008 imem_req  out  1  instruction memory read request.
REQ-009 imem_addr  out  32  word-aligned fetch address.
REQ-010 imem_rdata  in  32  instruction word; valid only in an imem_ack cycle.
REQ-011 imem_ack  in  1  read completes this cycle; memory asserts it only while imem_req=1.
REQ-012 id_pc  out  32  PC of the presented instruction, driving the ID_STATE pc field.
REQ-013 id_instruction  out  32  presented instruction, driving the ID_STATE instruction field.
REQ-014 id_valid  out  1  presented instruction is real; drives the decoder valid input.

Function
REQ-015 The block SHALL keep an internal fetch PC and run a 3-state FSM: S_IDLE, S_FETCH and S_HOLD.
REQ-016 S_IDLE SHALL be entered only by reset, last exactly one cycle with imem_req=0, then go to S_FETCH.
REQ-017 In S_FETCH the block SHALL drive imem_req=1 and imem_addr=pc.
REQ-018 While imem_req=1 without imem_ack, the block SHALL hold imem_addr stable unless jmp=1.
REQ-019 An S_FETCH cycle with imem_ack=1, stall=0 and jmp=0 SHALL register id_instruction<=imem_rdata, id_pc<=pc, id_valid<=1 and pc<=pc+4, and stay in S_FETCH.
REQ-020 The block SHALL have a latency of one cycle from ack to ID output and a throughput of one instruction per cycle with a zero-wait memory.
REQ-021 An S_FETCH cycle with imem_ack=0, stall=0 and jmp=0 SHALL register id_valid<=0 and id_instruction<=NOP_INSTR, a bubble with id_pc unchanged.
REQ-022 While stall=1 and jmp=0, the block SHALL hold id_pc, id_instruction and id_valid unchanged.
REQ-023 If imem_ack=1 arrives during a stall in S_FETCH, the block SHALL capture rdata and pc into a 1-entry skid buffer, set pc<=pc+4, and enter S_HOLD.
REQ-024 In S_HOLD the block SHALL drive imem_req=0, and SHALL stay in S_HOLD while stall=1.
REQ-025 In S_HOLD with stall=0 and jmp=0, the skid-buffer contents SHALL move to the ID outputs with id_valid=1, and the FSM SHALL return to S_FETCH.
REQ-026 jmp=1 SHALL take priority over stall and imem_ack in any non-IDLE state.
REQ-027 On jmp=1 the block SHALL set pc<=jmp_pc with bits [1:0] forced to 0, id_valid<=0, id_instruction<=NOP_INSTR, discard the skid buffer and any same-cycle ack data, and enter S_FETCH.
REQ-028 The first request after a jump SHALL appear in the cycle after jmp with imem_addr equal to the new pc.
REQ-029 pc+4 SHALL wrap modulo 2^32, so that 32'hFFFF_FFFC is followed by 32'h0000_0000.
REQ-030 imem_addr[1:0] SHALL always be 2'b00.
REQ-031 No instruction SHALL be duplicated or dropped across any stall pattern, except instructions flushed by jmp.

Reset
REQ-032 On a clock edge with rst=1 the block SHALL set state=S_IDLE, pc=RESET_PC, imem_req=0, id_valid=0, id_pc=0, id_instruction=NOP_INSTR, and clear the skid buffer.
REQ-033 Reset SHALL override jmp, stall and imem_ack, and an ack present in a reset cycle SHALL be ignored.
REQ-034 Reset asserted mid-stream SHALL return the block to the REQ-032 values on the next edge, with no output from in-flight fetches.

Verification
REQ-035 Reset release, zero-wait memory returning word = address -> imem_addr 0,4,8,... on consecutive cycles; id_valid first rises 2 cycles after reset release with id_pc=0; then one instruction per cycle.
REQ-036 Memory ack delayed 3 cycles for addr 8 -> imem_addr held at 8 for 4 cycles; id_valid=0 for 3 cycles; then id_pc=8.
REQ-037 stall=1 for 2 cycles while ack arrives for addr 12 -> id_pc=8 held; S_HOLD entered with imem_req=0; after release id_pc=12 then 16, with no duplicate or skipped instruction.
REQ-038 jmp=1 with jmp_pc=32'h0000_0103 and simultaneous stall=1 and ack -> next cycle id_valid=0, imem_addr=32'h0000_0100; the following output has id_pc=32'h100.
REQ-039 Redirect to 32'hFFFF_FFFC -> fetches FFFF_FFFC then 0000_0000.
REQ-040 rst=1 asserted in S_HOLD with an ack present -> next cycle all REQ-032 values; first fetch from RESET_PC after release.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: a single-request fetcher feeding the decoder's ID_STATE registers.
// A one-entry skid buffer catches a fetch that completes while the decoder is stalled.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jmp,
  input  logic [31:0] jmp_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] id_pc,
  output logic [31:0] id_instruction,
  output logic        id_valid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;
  logic        skid_vld;

  // pc only moves on a completed fetch or a redirect, so the address is stable while waiting
  assign pc_inc    = pc + 32'd4;
  assign imem_req  = (state == S_FETCH);
  assign imem_addr = {pc[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      pc             <= {RESET_PC[31:2], 2'b00};
      id_valid       <= 1'b0;
      id_pc          <= 32'h0000_0000;
      id_instruction <= NOP_INSTR;
      skid_vld       <= 1'b0;
      skid_pc        <= 32'h0000_0000;
      skid_instr     <= NOP_INSTR;
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;

        S_FETCH: begin
          if (jmp) begin
            pc             <= {jmp_pc[31:2], 2'b00};
            id_valid       <= 1'b0;
            id_instruction <= NOP_INSTR;
            skid_vld       <= 1'b0;
          end else if (imem_ack && !stall) begin
            id_instruction <= imem_rdata;
            id_pc          <= pc;
            id_valid       <= 1'b1;
            pc             <= pc_inc;
          end else if (imem_ack) begin
            // decoder is stalled: park the word so it is neither lost nor refetched
            skid_instr <= imem_rdata;
            skid_pc    <= pc;
            skid_vld   <= 1'b1;
            pc         <= pc_inc;
            state      <= S_HOLD;
          end else if (!stall) begin
            id_valid       <= 1'b0;
            id_instruction <= NOP_INSTR;
          end
        end

        S_HOLD: begin
          if (jmp) begin
            pc             <= {jmp_pc[31:2], 2'b00};
            id_valid       <= 1'b0;
            id_instruction <= NOP_INSTR;
            skid_vld       <= 1'b0;
            state          <= S_FETCH;
          end else if (!stall) begin
            id_instruction <= skid_instr;
            id_pc          <= skid_pc;
            id_valid       <= skid_vld;
            skid_vld       <= 1'b0;
            state          <= S_FETCH;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a per-cycle vector table plus a short hand-written redirect-from-hold case.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        jmp = 1'b0;
  logic [31:0] jmp_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_instruction;
  logic        id_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // memory returns word == address
  assign imem_rdata = imem_addr;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .jmp(jmp), .jmp_pc(jmp_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .id_pc(id_pc), .id_instruction(id_instruction),
    .id_valid(id_valid)
  );

  typedef struct {
    logic        rst, stall, jmp, ack;
    logic [31:0] jmp_pc;
    logic        chk;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic s, logic j, logic [31:0] jp, logic a, logic c,
                              logic rq, logic [31:0] ad, logic v, logic [31:0] p, logic [31:0] ins);
    vec_t t;
    t.rst = r; t.stall = s; t.jmp = j; t.jmp_pc = jp; t.ack = a; t.chk = c;
    t.req = rq; t.addr = ad; t.valid = v; t.pc = p; t.instr = ins;
    return t;
  endfunction

  task automatic check32(string name, int step, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  task automatic check_all(int step, logic rq, logic [31:0] ad, logic v, logic [31:0] p, logic [31:0] ins);
    check32("imem_req", step, {31'b0, imem_req}, {31'b0, rq});
    check32("imem_addr", step, imem_addr, ad);
    check32("id_valid", step, {31'b0, id_valid}, {31'b0, v});
    check32("id_pc", step, id_pc, p);
    check32("id_instruction", step, id_instruction, ins);
  endtask

  task automatic drive(logic r, logic s, logic j, logic [31:0] jp, logic a);
    rst = r; stall = s; jmp = j; jmp_pc = jp; imem_ack = a;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    //           rst st jmp jmp_pc        ack chk req addr          vld id_pc         id_instr
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        NOP));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0,        NOP));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0,        NOP));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 1, 32'h0,        0, 32'h0,        NOP));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 1, 32'h4,        1, 32'h0,        32'h0));
    // ack for address 8 delayed three cycles
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 1, 32'h8,        1, 32'h4,        32'h4));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 1, 32'h8,        0, 32'h4,        NOP));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 1, 32'h8,        0, 32'h4,        NOP));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 1, 32'h8,        0, 32'h4,        NOP));
    // stall for two cycles while address 12 completes
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 32'hC,        1, 32'h8,        32'h8));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h10,       1, 32'h8,        32'h8));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 0, 32'h10,       1, 32'h8,        32'h8));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 1, 32'h10,       1, 32'hC,        32'hC));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 1, 32'h14,       1, 32'h10,       32'h10));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 1, 32'h14,       0, 32'h10,       NOP));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 1, 32'h14,       0, 32'h10,       NOP));
    // jump with simultaneous stall and ack
    tbl.push_back(mk(0, 1, 1, 32'h103,      1, 1, 1, 32'h18,       1, 32'h14,       32'h14));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 1, 32'h100,      0, 32'h14,       NOP));
    // redirect to the top of the address space
    tbl.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 0, 1, 1, 32'h104,     1, 32'h100,      32'h100));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 1, 32'hFFFF_FFFC, 0, 32'h100,     NOP));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 1, 32'h0,        1, 32'hFFFF_FFFC, 32'hFFFF_FFFC));
    // enter hold, then reset with an ack present
    tbl.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 32'h4,        1, 32'h0,        32'h0));
    tbl.push_back(mk(1, 1, 1, 32'h200,      1, 1, 0, 32'h8,        1, 32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0,        NOP));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 1, 32'h0,        0, 32'h0,        NOP));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].stall, tbl[i].jmp, tbl[i].jmp_pc, tbl[i].ack);
      #1;
      if (tbl[i].chk)
        check_all(i, tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].pc, tbl[i].instr);
    end

    // redirect while holding a skid word: the parked word must be discarded
    @(negedge clk);
    drive(0, 1, 0, 32'h0, 1);
    #1 check_all(100, 1, 32'h0, 0, 32'h0, NOP);
    @(negedge clk);
    drive(0, 1, 1, 32'h43, 0);
    #1 check_all(101, 0, 32'h4, 0, 32'h0, NOP);
    @(negedge clk);
    drive(0, 0, 0, 32'h0, 1);
    #1 check_all(102, 1, 32'h40, 0, 32'h0, NOP);
    @(negedge clk);
    drive(0, 0, 0, 32'h0, 0);
    #1 check_all(103, 1, 32'h44, 1, 32'h40, 32'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
